// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data traffic.
// Data has fixed priority; a starvation counter forces fetch through after STARVE_LIMIT losses.
//
// state  | meaning
// IDLE   | port free, grants may issue this cycle
// BUSY_F | fetch access outstanding, waiting for mem_ack
// BUSY_D | data access outstanding, waiting for mem_ack
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [63:0]       d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              stray_ack
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] starve_cnt;
  logic       f_win;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (f_gnt) begin
          state_nxt = BUSY_F;
        end else if (d_gnt) begin
          state_nxt = BUSY_D;
        end
      end
      BUSY_F: begin
        if (mem_ack) begin
          state_nxt = IDLE;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fetch only beats a pending data request once it has been starved long enough.
  always_comb begin
    f_win = f_req && (!d_req || (starve_cnt == STARVE_MAX));
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (state == IDLE) begin
      f_gnt = f_win;
      d_gnt = d_req && !f_win;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (f_gnt) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= f_addr;
      mem_wdata <= '0;
    end else if (d_gnt) begin
      mem_req   <= 1'b1;
      mem_we    <= d_we;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
    end else if (mem_ack && (state != IDLE)) begin
      mem_req <= 1'b0;
    end
  end

  // Completion: mem_we still holds the captured direction of the outstanding access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_rvalid <= 1'b0;
      f_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
    end else begin
      f_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      if (mem_ack && (state == BUSY_F)) begin
        f_rvalid <= 1'b1;
        f_rdata  <= mem_rdata[31:0];
      end
      if (mem_ack && (state == BUSY_D)) begin
        d_rvalid <= 1'b1;
        d_rdata  <= mem_we ? 64'h0 : mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (f_gnt) begin
      starve_cnt <= '0;
    end else if (d_gnt && f_req && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stray_ack <= 1'b0;
    end else if (mem_ack && (state == IDLE)) begin
      stray_ack <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-programmable memory responder.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [63:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  logic        stray_ack;

  logic resp_ack = 1'b0;
  logic man_ack  = 1'b0;
  logic resp_en  = 1'b1;
  int   lat      = 2;
  int   cyc      = 0;
  int   n_vec    = 0;
  int   n_err    = 0;

  assign mem_ack = resp_ack | man_ack;

  mem_port_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stray_ack(stray_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder: ack lands in the lat-th cycle that mem_req is high.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_en && mem_req && !resp_ack) begin
        cnt++;
        if (cnt == lat) begin
          resp_ack = 1'b1;
          cnt = 0;
        end
      end else begin
        resp_ack = 1'b0;
        if (!mem_req) cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    bit exp_f [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int t;
    int last;

    reset = 1'b1;
    f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0;

    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_f_rdata", f_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_stray", stray_ack, 0);
    chk("rst_gnt", {f_gnt, d_gnt, f_rvalid, d_rvalid}, 0);
    reset = 1'b0;

    // Fetch only
    @(negedge clk);
    lat = 2;
    f_req = 1'b1; f_addr = 32'h2000;
    mem_rdata = 64'h0000_0000_C840_0004;
    #1;
    chk("t1_f_gnt", f_gnt, 1);
    chk("t1_d_gnt", d_gnt, 0);
    @(negedge clk);
    f_req = 1'b0;
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h2000);
    chk("t1_mem_we", mem_we, 0);
    @(negedge clk);
    chk("t1_ack_cycle", mem_ack, 1);
    chk("t1_rv_early", f_rvalid, 0);
    @(negedge clk);
    chk("t1_f_rvalid", f_rvalid, 1);
    chk("t1_f_rdata", f_rdata, 32'hC840_0004);
    chk("t1_mem_req_off", mem_req, 0);
    @(negedge clk);
    chk("t1_rv_pulse", f_rvalid, 0);
    chk("t1_rdata_hold", f_rdata, 32'hC840_0004);

    // Simultaneous requests: data first, fetch granted alongside d_rvalid
    f_req = 1'b1; f_addr = 32'h3000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10000;
    mem_rdata = 64'h1122_3344_5566_7788;
    #1;
    chk("t2_d_gnt", d_gnt, 1);
    chk("t2_f_gnt", f_gnt, 0);
    @(negedge clk);
    d_req = 1'b0;
    chk("t2_mem_addr", mem_addr, 32'h10000);
    chk("t2_busy_no_gnt", f_gnt, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t2_d_rvalid", d_rvalid, 1);
    chk("t2_d_rdata", d_rdata, 64'h1122_3344_5566_7788);
    chk("t2_f_gnt_same", f_gnt, 1);
    @(negedge clk);
    f_req = 1'b0;
    chk("t2_f_mem_addr", mem_addr, 32'h3000);
    @(negedge clk);
    @(negedge clk);
    chk("t2_f_rvalid", f_rvalid, 1);
    chk("t2_f_rdata", f_rdata, 32'h5566_7788);

    // Starvation guard: D D D D F, then D again since the counter cleared
    @(negedge clk);
    f_req = 1'b1; f_addr = 32'h4000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000;
    #1;
    for (int g = 0; g < 6; g++) begin
      t = 0;
      while (!(f_gnt || d_gnt) && t < 10) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("t3_timeout_%0d", g), (t < 10), 1);
      chk($sformatf("t3_f_gnt_%0d", g), f_gnt, exp_f[g]);
      chk($sformatf("t3_d_gnt_%0d", g), d_gnt, !exp_f[g]);
      @(negedge clk);
    end
    f_req = 1'b0; d_req = 1'b0;
    repeat (4) @(negedge clk);

    // Store with latency 3
    lat = 3;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'hFFF8; d_wdata = 64'h2004;
    mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    #1;
    chk("t4_d_gnt", d_gnt, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        d_req = 1'b0; d_we = 1'b0;
        chk("t4_mem_addr", mem_addr, 32'hFFF8);
      end
      chk($sformatf("t4_mem_req_%0d", i), mem_req, 1);
      chk($sformatf("t4_mem_we_%0d", i), mem_we, 1);
      chk($sformatf("t4_wdata_%0d", i), mem_wdata, 64'h2004);
      chk($sformatf("t4_no_rv_%0d", i), d_rvalid, 0);
    end
    @(negedge clk);
    chk("t4_d_rvalid", d_rvalid, 1);
    chk("t4_d_rdata", d_rdata, 64'h0);
    chk("t4_mem_req_off", mem_req, 0);

    // Reset mid-access, then a late ack
    @(negedge clk);
    resp_en = 1'b0;
    lat = 2;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    #1;
    chk("t5_d_gnt", d_gnt, 1);
    @(negedge clk);
    d_req = 1'b0;
    chk("t5_mem_req", mem_req, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_drop", mem_req, 0);
    chk("t5_stray_pre", stray_ack, 0);
    @(negedge clk);
    reset = 1'b0;
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    chk("t5_stray_set", stray_ack, 1);
    chk("t5_no_rvalid", d_rvalid, 0);
    @(negedge clk);
    chk("t5_no_rvalid_late", d_rvalid, 0);
    chk("t5_stray_sticky", stray_ack, 1);
    resp_en = 1'b1;

    // Back-to-back fetches, latency 2: a grant every 3 cycles
    @(negedge clk);
    f_req = 1'b1; f_addr = 32'h2000;
    #1;
    last = 0;
    for (int k = 0; k < 3; k++) begin
      t = 0;
      while (!f_gnt && t < 10) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("t6_timeout_%0d", k), (t < 10), 1);
      if (k > 0) chk($sformatf("t6_period_%0d", k), cyc - last, 3);
      last = cyc;
      @(negedge clk);
      chk($sformatf("t6_addr_%0d", k), mem_addr, 32'h2000 + 32'(4 * k));
      if (k < 2) f_addr = f_addr + 32'h4;
      else f_req = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("t6_stray_still", stray_ack, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
